wall_clock_counter: RTL and testbench
=====================================

WALL_CLOCK_COUNTER -- requirements
Module: wall_clock_counter

Interface
REQ-001 SHALL have parameter MODE_24H, default 1, meaning 1 = 24-hour display (00-23) and 0 = 12-hour display (01-12 with pm flag).
REQ-002 SHALL have one clock and a reset that is synchronous and active-high, on the ports below.
REQ-003 SHALL have port clk256  input  1  -- 256 Hz system clock, the only clock.
REQ-004 SHALL have port reset  input  1  -- synchronous, active-high.
REQ-005 SHALL have port one_second  input  1  -- seconds tick level, synchronous to clk256.
REQ-006 SHALL have port one_minute  input  1  -- minutes tick level, synchronous to clk256.
REQ-007 SHALL have port load_valid  input  1  -- time-set request.
REQ-008 SHALL have port load_ready  output  1  -- block can accept a load.
REQ-009 SHALL have port load_hh  input  8  -- BCD hours to load.
REQ-010 SHALL have port load_mm  input  8  -- BCD minutes to load.
REQ-011 SHALL have port load_error  output  1  -- one-cycle pulse when a load is rejected.
REQ-012 SHALL have port hours_bcd  output  8  -- current hours, BCD.
REQ-013 SHALL have port minutes_bcd  output  8  -- current minutes, BCD.
REQ-014 SHALL have port seconds  output  6  -- seconds within the minute, binary 0-59.
REQ-015 SHALL have port pm  output  1  -- pm flag; constant 0 when MODE_24H=1.
REQ-016 SHALL have ports alarm_hh/alarm_mm (input, 8 each, BCD), alarm_arm (input, 1), alarm_stop (input, 1) and alarm_active (output, 1).

Function
REQ-017 SHALL register both tick inputs each cycle; a tick event is input=1 while the previous-cycle sample=0.
REQ-018 SHALL update counters on the clk256 edge that detects the event; new values are visible one cycle later.
REQ-019 SHALL increment seconds on a one_second event, 59 -> 0, with no carry into minutes.
REQ-020 SHALL, on a one_minute event, clear seconds to 0 and increment minutes BCD (x9 -> (x+1)0, 59 -> 00 with a carry to hours).
REQ-021 SHALL wrap hours 23:59 -> 00:00 when MODE_24H=1.
REQ-022 SHALL, when MODE_24H=0, wrap 12:59 -> 01:00 with pm unchanged, and go 11:59 -> 12:00 with pm toggled.
REQ-023 SHALL implement the load FSM:
 - IDLE (load_ready=1): on load_valid go to CHECK.
 - CHECK (load_ready=0): if valid, write load_hh/load_mm, clear seconds and pm, and go to DONE; else pulse load_error and go to DONE.
 - DONE (load_ready=0): go to IDLE when load_valid=0.
REQ-024 SHALL treat a load as valid only when every nibble is <=9, minutes <=59, and hours are 00-23 (24h) or 01-12 (12h).
REQ-025 SHALL give a load write priority over a tick in the same cycle; that tick is dropped.
REQ-026 SHALL process a one_second event and a one_minute event in the same cycle as a minute event, leaving seconds=0.
REQ-027 SHALL never produce a non-BCD or out-of-range value on hours_bcd or minutes_bcd.

Reset
REQ-028 SHALL on reset set hours_bcd=00 (24h) or 12 (12h), minutes_bcd=00, seconds=0, pm=0, load_error=0, alarm_active=0, FSM=IDLE, load_ready=1, and tick samples=0.
REQ-029 SHALL let reset asserted mid-load override everything, with the load discarded.

Configuration
REQ-030 SHALL compile the alarm in under macro WALL_CLOCK_ALARM_EN.
REQ-031 SHALL, when WALL_CLOCK_ALARM_EN is defined, set alarm_active on the cycle after a minute increment or load that makes hours:minutes equal alarm_hh:alarm_mm while alarm_arm=1.
REQ-032 SHALL, when WALL_CLOCK_ALARM_EN is defined, hold alarm_active until alarm_stop=1, alarm_arm=0 or reset; alarm_stop SHALL win over a simultaneous match.
REQ-033 SHALL, when WALL_CLOCK_ALARM_EN is not defined, keep the alarm ports, ignore the alarm inputs and hold alarm_active at 0.

Structure
REQ-034 SHALL place the BCD byte typedef, the constants MAX_SEC=59, MAX_MIN=0x59, MAX_H24=0x23 and MAX_H12=0x12, and the load-FSM state enum in shared package time_pkg.
REQ-035 SHALL use one sub-module, bcd_mod_counter (two-digit BCD counter with programmable wrap, wrap-to value, load and carry-out), instantiated for minutes and for hours.

Verification
REQ-036 SHALL cover: reset, then 60 one_minute events -> hours_bcd=0x01, minutes_bcd=0x00.
REQ-037 SHALL cover: load 23:59 (24h), then one minute event -> 00:00; with MODE_24H=0, load 11:59 then one event -> 12:00 with pm=1, then 60 events -> 01:00 with pm=1.
REQ-038 SHALL cover: load_hh=0x24 or load_mm=0x5A -> load_error pulses for one cycle and the time is unchanged.
REQ-039 SHALL cover: load_valid in the same cycle as a one_minute edge -> the loaded value is held and the tick is lost.
REQ-040 SHALL cover: one_second held high for 3 cycles -> seconds increments once; 61 edges -> seconds=1.
REQ-041 SHALL cover, with WALL_CLOCK_ALARM_EN: alarm 07:00 armed, time 06:59 plus a minute event -> alarm_active=1 next cycle; alarm_stop -> 0.

Source files
------------

// File: rtl/time_pkg.sv
// Shared types, limits, load-FSM states and BCD helpers for the wall clock counter.
package time_pkg;

   typedef logic [7:0] bcd8_t;

   localparam int unsigned MAX_SEC = 59;
   localparam bcd8_t       MAX_MIN = 8'h59;
   localparam bcd8_t       MAX_H24 = 8'h23;
   localparam bcd8_t       MAX_H12 = 8'h12;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_CHECK = 2'd1,
      LD_DONE  = 2'd2
   } load_state_t;

   function automatic bcd8_t bcd_inc(input bcd8_t v);
      bcd8_t r;
      if (v[3:0] >= 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic bcd_digits_ok(input bcd8_t v);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   // Digit check first, so the numeric range compares below are on genuine BCD.
   function automatic logic load_ok(input bcd8_t hh, input bcd8_t mm, input logic mode_24h);
      logic ok;
      ok = bcd_digits_ok(hh) && bcd_digits_ok(mm) && (mm <= MAX_MIN);
      if (mode_24h) ok = ok && (hh <= MAX_H24);
      else          ok = ok && (hh != 8'h00) && (hh <= MAX_H12);
      return ok;
   endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter with programmable wrap point, wrap-to value, load and carry-out.
module bcd_mod_counter
   import time_pkg::*;
#(
   parameter bcd8_t MAX_VAL   = MAX_MIN,
   parameter bcd8_t WRAP_VAL  = 8'h00,
   parameter bcd8_t RESET_VAL = 8'h00
) (
   input  logic  clk,
   input  logic  reset,
   input  logic  inc,
   input  logic  load,
   input  bcd8_t load_value,
   output bcd8_t value,
   output bcd8_t next_value,
   output logic  carry
);

   // Load wins over increment; carry is only raised by an increment that wraps.
   always_comb begin
      next_value = value;
      carry      = 1'b0;
      if (load) begin
         next_value = load_value;
      end else if (inc) begin
         if (value == MAX_VAL) begin
            next_value = WRAP_VAL;
            carry      = 1'b1;
         end else begin
            next_value = bcd_inc(value);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) value <= RESET_VAL;
      else       value <= next_value;
   end

endmodule

// File: rtl/wall_clock_counter.sv
// Wall clock: edge-detected second/minute ticks, BCD hh:mm, binary seconds, validated time load.
// Optional alarm logic is compiled in with `define WALL_CLOCK_ALARM_EN.
module wall_clock_counter
   import time_pkg::*;
#(
   parameter int MODE_24H = 1
) (
   input  logic       clk256,
   input  logic       reset,
   input  logic       one_second,
   input  logic       one_minute,
   input  logic       load_valid,
   output logic       load_ready,
   input  logic [7:0] load_hh,
   input  logic [7:0] load_mm,
   output logic       load_error,
   output logic [7:0] hours_bcd,
   output logic [7:0] minutes_bcd,
   output logic [5:0] seconds,
   output logic       pm,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_arm,
   input  logic       alarm_stop,
   output logic       alarm_active
);

   localparam logic  IS_24H    = (MODE_24H != 0);
   localparam bcd8_t HOUR_MAX  = IS_24H ? MAX_H24 : MAX_H12;
   localparam bcd8_t HOUR_WRAP = IS_24H ? 8'h00 : 8'h01;
   localparam bcd8_t HOUR_RST  = IS_24H ? 8'h00 : MAX_H12;

   load_state_t state;
   logic        sec_q, min_q;
   logic        sec_ev, min_ev;
   logic        load_wr, min_inc, sec_inc;
   logic        min_carry, hour_carry_unused;
   bcd8_t       min_next, hour_next;

   always_ff @(posedge clk256) begin
      if (reset) begin
         sec_q <= 1'b0;
         min_q <= 1'b0;
      end else begin
         sec_q <= one_second;
         min_q <= one_minute;
      end
   end

   assign sec_ev  = one_second & ~sec_q;
   assign min_ev  = one_minute & ~min_q;
   assign load_wr = (state == LD_CHECK) && load_ok(load_hh, load_mm, IS_24H);
   // A load write swallows any tick in the same cycle; a minute tick subsumes a second tick.
   assign min_inc = min_ev & ~load_wr;
   assign sec_inc = sec_ev & ~min_ev & ~load_wr;

   always_ff @(posedge clk256) begin
      if (reset) begin
         state      <= LD_IDLE;
         load_ready <= 1'b1;
         load_error <= 1'b0;
      end else begin
         load_error <= 1'b0;
         case (state)
            LD_IDLE: begin
               if (load_valid) begin
                  state      <= LD_CHECK;
                  load_ready <= 1'b0;
               end
            end
            LD_CHECK: begin
               state      <= LD_DONE;
               load_error <= ~load_wr;
            end
            LD_DONE: begin
               if (!load_valid) begin
                  state      <= LD_IDLE;
                  load_ready <= 1'b1;
               end
            end
            default: begin
               state      <= LD_IDLE;
               load_ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk256) begin
      if (reset || load_wr || min_inc) seconds <= '0;
      else if (sec_inc)                seconds <= (seconds == 6'(MAX_SEC)) ? '0 : seconds + 6'd1;
   end

   bcd_mod_counter #(
      .MAX_VAL   (MAX_MIN),
      .WRAP_VAL  (8'h00),
      .RESET_VAL (8'h00)
   ) u_minutes (
      .clk        (clk256),
      .reset      (reset),
      .inc        (min_inc),
      .load       (load_wr),
      .load_value (load_mm),
      .value      (minutes_bcd),
      .next_value (min_next),
      .carry      (min_carry)
   );

   bcd_mod_counter #(
      .MAX_VAL   (HOUR_MAX),
      .WRAP_VAL  (HOUR_WRAP),
      .RESET_VAL (HOUR_RST)
   ) u_hours (
      .clk        (clk256),
      .reset      (reset),
      .inc        (min_carry),
      .load       (load_wr),
      .load_value (load_hh),
      .value      (hours_bcd),
      .next_value (hour_next),
      .carry      (hour_carry_unused)
   );

   generate
      if (IS_24H) begin : g_pm_24h
         assign pm = 1'b0;
      end else begin : g_pm_12h
         // pm flips only on the 11 -> 12 step; the 12 -> 01 wrap keeps it.
         always_ff @(posedge clk256) begin
            if (reset || load_wr)                       pm <= 1'b0;
            else if (min_carry && hours_bcd == 8'h11)   pm <= ~pm;
         end
      end
   endgenerate

`ifdef WALL_CLOCK_ALARM_EN
   // Matches against the post-update time so the flag rises together with the new hh:mm.
   always_ff @(posedge clk256) begin
      if (reset || alarm_stop || !alarm_arm)
         alarm_active <= 1'b0;
      else if ((min_inc || load_wr) && hour_next == alarm_hh && min_next == alarm_mm)
         alarm_active <= 1'b1;
   end
`else
   logic alarm_unused;
   assign alarm_unused = ^{alarm_hh, alarm_mm, alarm_arm, alarm_stop, hour_next, min_next};
   assign alarm_active = 1'b0;
`endif

endmodule

// File: tb/tb_wall_clock_counter.sv
// Bench for wall_clock_counter: a 12h and a 24h instance share stimulus; reference model keeps minute-of-day.
module tb_wall_clock_counter;

   logic       clk256 = 1'b0;
   logic       reset, one_second, one_minute, load_valid, alarm_arm, alarm_stop;
   logic [7:0] load_hh, load_mm, alarm_hh, alarm_mm;

   // index 0: MODE_24H=0 instance, index 1: MODE_24H=1 instance
   logic [7:0] hrs  [2];
   logic [7:0] mins [2];
   logic [5:0] secs [2];
   logic       pmo  [2];
   logic       rdy  [2];
   logic       err  [2];
   logic       alm  [2];

   int total = 0;
   int bad   = 0;

   int t_m [2];
   int s_m [2];
   bit al_m[2];
   bit ps_m, pm_m;

`ifdef WALL_CLOCK_ALARM_EN
   localparam bit ALARM_ON = 1'b1;
`else
   localparam bit ALARM_ON = 1'b0;
`endif

   always #5 clk256 = ~clk256;

   wall_clock_counter #(.MODE_24H(0)) dut12 (
      .clk256(clk256), .reset(reset), .one_second(one_second), .one_minute(one_minute),
      .load_valid(load_valid), .load_ready(rdy[0]), .load_hh(load_hh), .load_mm(load_mm),
      .load_error(err[0]), .hours_bcd(hrs[0]), .minutes_bcd(mins[0]), .seconds(secs[0]),
      .pm(pmo[0]), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
      .alarm_stop(alarm_stop), .alarm_active(alm[0])
   );

   wall_clock_counter #(.MODE_24H(1)) dut24 (
      .clk256(clk256), .reset(reset), .one_second(one_second), .one_minute(one_minute),
      .load_valid(load_valid), .load_ready(rdy[1]), .load_hh(load_hh), .load_mm(load_mm),
      .load_error(err[1]), .hours_bcd(hrs[1]), .minutes_bcd(mins[1]), .seconds(secs[1]),
      .pm(pmo[1]), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm),
      .alarm_stop(alarm_stop), .alarm_active(alm[1])
   );

   // ---------------- reference model ----------------
   function automatic logic [7:0] to_bcd(input int v);
      return 8'((v / 10) * 16 + (v % 10));
   endfunction

   function automatic logic [7:0] exp_h(input int i);
      int h;
      h = t_m[i] / 60;
      if (i == 1) return to_bcd(h);
      return to_bcd((h % 12 == 0) ? 12 : h % 12);
   endfunction

   function automatic logic [22:0] exp_vec(input int i);
      return {exp_h(i), to_bcd(t_m[i] % 60), 6'(s_m[i]), (i == 0) && (t_m[i] >= 720)};
   endfunction

   function automatic logic [22:0] obs_vec(input int i);
      return {hrs[i], mins[i], secs[i], pmo[i]};
   endfunction

   function automatic bit ld_ok(input int i, input logic [7:0] hh, input logic [7:0] mm);
      int hv, mv;
      if (hh[7:4] > 9 || hh[3:0] > 9 || mm[7:4] > 9 || mm[3:0] > 9) return 0;
      hv = hh[7:4] * 10 + hh[3:0];
      mv = mm[7:4] * 10 + mm[3:0];
      if (mv > 59) return 0;
      return (i == 1) ? (hv <= 23) : (hv >= 1 && hv <= 12);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         t_m[i] = 0; s_m[i] = 0; al_m[i] = 0;
      end
      ps_m = 0; pm_m = 0;
   endtask

   task automatic model_edge(input bit w0, input bit w1);
      bit sev, mev;
      bit w[2];
      int hv, mv;
      w[0] = w0; w[1] = w1;
      sev = one_second && !ps_m;
      mev = one_minute && !pm_m;
      ps_m = one_second; pm_m = one_minute;
      hv = load_hh[7:4] * 10 + load_hh[3:0];
      mv = load_mm[7:4] * 10 + load_mm[3:0];
      for (int i = 0; i < 2; i++) begin
         if (w[i]) begin
            t_m[i] = ((i == 0 && hv == 12) ? 0 : hv) * 60 + mv;
            s_m[i] = 0;
         end else if (mev) begin
            t_m[i] = (t_m[i] + 1) % 1440;
            s_m[i] = 0;
         end else if (sev) begin
            s_m[i] = (s_m[i] + 1) % 60;
         end
`ifdef WALL_CLOCK_ALARM_EN
         if (alarm_stop || !alarm_arm) al_m[i] = 0;
         else if ((w[i] || mev) && exp_h(i) == alarm_hh && to_bcd(t_m[i] % 60) == alarm_mm)
            al_m[i] = 1;
`else
         al_m[i] = 0;
`endif
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic clk_step(input bit w0, input bit w1);
      @(posedge clk256);
      if (reset) model_reset();
      else       model_edge(w0, w1);
      #1;
   endtask

   // Leaves the FSM in DONE with load_valid still high; load_error is observable now.
   task automatic load_start(input logic [7:0] hh, input logic [7:0] mm, input bit tick);
      load_hh = hh; load_mm = mm; load_valid = 1'b1;
      clk_step(0, 0);
      if (tick) one_minute = 1'b1;
      clk_step(ld_ok(0, hh, mm), ld_ok(1, hh, mm));
   endtask

   task automatic load_end();
      load_valid = 1'b0;
      one_minute = 1'b0;
      clk_step(0, 0);
   endtask

   task automatic pulse_min();
      one_minute = 1'b1; clk_step(0, 0);
      one_minute = 1'b0; clk_step(0, 0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      clk_step(0, 0); clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL reset_time dut%0d got %h want %h", i, obs_vec(i), exp_vec(i)); end
         total++; if ({rdy[i], err[i], alm[i]} !== 3'b100) begin bad++; $display("FAIL reset_flags dut%0d got %b want 100", i, {rdy[i], err[i], alm[i]}); end
      end
      total++; if ({hrs[0], hrs[1]} !== 16'h1200) begin bad++; $display("FAIL reset_hours got %h want 1200", {hrs[0], hrs[1]}); end
      reset = 1'b0;
      clk_step(0, 0);
      // reset arriving while the load is in CHECK must discard it
      load_hh = 8'h05; load_mm = 8'h30; load_valid = 1'b1;
      clk_step(0, 0);
      reset = 1'b1; clk_step(0, 0);
      reset = 1'b0; load_valid = 1'b0; clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL midload_reset dut%0d got %h want %h", i, obs_vec(i), exp_vec(i)); end
         total++; if (rdy[i] !== 1'b1) begin bad++; $display("FAIL midload_ready dut%0d got %b want 1", i, rdy[i]); end
      end
   endtask

   task automatic test_minute_rollover();
      reset = 1'b1; clk_step(0, 0); reset = 1'b0;
      for (int n = 0; n < 60; n++) begin
         one_second = 1'($urandom % 2); one_minute = 1'b1; clk_step(0, 0);
         for (int i = 0; i < 2; i++) begin
            total++; if (obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL minute_step%0d dut%0d got %h want %h", n, i, obs_vec(i), exp_vec(i)); end
         end
         one_second = 1'($urandom % 2); one_minute = 1'b0; clk_step(0, 0);
      end
      one_second = 1'b0;
      total++; if ({hrs[1], mins[1]} !== 16'h0100) begin bad++; $display("FAIL rollover_24h got %h want 0100", {hrs[1], mins[1]}); end
      total++; if ({hrs[0], mins[0], pmo[0]} !== {8'h01, 8'h00, 1'b0}) begin bad++; $display("FAIL rollover_12h got %h want %h", {hrs[0], mins[0], pmo[0]}, {8'h01, 8'h00, 1'b0}); end
   endtask

   task automatic test_wrap();
      load_start(8'h23, 8'h59, 0);
      total++; if ({err[0], err[1]} !== 2'b10) begin bad++; $display("FAIL wrap_load_err got %b want 10", {err[0], err[1]}); end
      load_end();
      pulse_min();
      total++; if ({hrs[1], mins[1]} !== 16'h0000) begin bad++; $display("FAIL wrap_24h got %h want 0000", {hrs[1], mins[1]}); end
      load_start(8'h11, 8'h59, 0); load_end();
      pulse_min();
      total++; if ({hrs[0], mins[0], pmo[0]} !== {8'h12, 8'h00, 1'b1}) begin bad++; $display("FAIL noon_12h got %h want %h", {hrs[0], mins[0], pmo[0]}, {8'h12, 8'h00, 1'b1}); end
      for (int n = 0; n < 60; n++) pulse_min();
      total++; if ({hrs[0], mins[0], pmo[0]} !== {8'h01, 8'h00, 1'b1}) begin bad++; $display("FAIL one_pm_12h got %h want %h", {hrs[0], mins[0], pmo[0]}, {8'h01, 8'h00, 1'b1}); end
      for (int i = 0; i < 2; i++) begin
         total++; if (obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL wrap_model dut%0d got %h want %h", i, obs_vec(i), exp_vec(i)); end
      end
   endtask

   task automatic test_second_ticks();
      load_start(8'h10, 8'h00, 0); load_end();
      for (int n = 0; n < 61; n++) begin
         one_second = 1'b1; clk_step(0, 0);
         one_second = 1'b0; clk_step(0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         total++; if (secs[i] !== 6'd1 || obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL sec_61_edges dut%0d got %0d want 1", i, secs[i]); end
      end
      one_second = 1'b1;
      repeat (3) clk_step(0, 0);
      one_second = 1'b0; clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (secs[i] !== 6'd2 || obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL sec_held_level dut%0d got %0d want 2", i, secs[i]); end
      end
   endtask

   task automatic test_load_error();
      logic [15:0] fixed [2];
      logic [7:0]  hh, mm;
      fixed[0] = 16'h2400; fixed[1] = 16'h125A;
      load_start(8'h09, 8'h15, 0); load_end();
      for (int k = 0; k < 10; k++) begin
         if (k < 2) begin hh = fixed[k][15:8]; mm = fixed[k][7:0]; end
         else begin hh = 8'($urandom_range(0, 63)); mm = 8'($urandom_range(0, 127)); end
         load_start(hh, mm, 0);
         if (k < 2) begin
            total++; if (err[1] !== 1'b1) begin bad++; $display("FAIL bad_load_err%0d got %b want 1", k, err[1]); end
         end
         for (int i = 0; i < 2; i++) begin
            total++; if ({err[i], rdy[i]} !== {!ld_ok(i, hh, mm), 1'b0}) begin bad++; $display("FAIL load_err dut%0d %h:%h got %b want %b", i, hh, mm, {err[i], rdy[i]}, {!ld_ok(i, hh, mm), 1'b0}); end
            total++; if (obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL load_time dut%0d %h:%h got %h want %h", i, hh, mm, obs_vec(i), exp_vec(i)); end
         end
         load_end();
         for (int i = 0; i < 2; i++) begin
            total++; if ({err[i], rdy[i]} !== 2'b01) begin bad++; $display("FAIL load_after dut%0d got %b want 01", i, {err[i], rdy[i]}); end
         end
      end
   endtask

   task automatic test_load_vs_tick();
      load_start(8'h08, 8'h30, 1);
      total++; if ({hrs[1], mins[1], secs[1]} !== {8'h08, 8'h30, 6'd0}) begin bad++; $display("FAIL load_tick_prio got %h want %h", {hrs[1], mins[1], secs[1]}, {8'h08, 8'h30, 6'd0}); end
      load_end();
      pulse_min();
      for (int i = 0; i < 2; i++) begin
         total++; if (obs_vec(i) !== exp_vec(i) || mins[i] !== 8'h31) begin bad++; $display("FAIL after_dropped_tick dut%0d got %h want %h", i, obs_vec(i), exp_vec(i)); end
      end
   endtask

   task automatic test_alarm();
      alarm_hh = 8'h07; alarm_mm = 8'h00; alarm_arm = 1'b1; alarm_stop = 1'b0;
      load_start(8'h06, 8'h59, 0); load_end();
      one_minute = 1'b1; clk_step(0, 0);
      total++; if (alm[1] !== ALARM_ON) begin bad++; $display("FAIL alarm_rise got %b want %b", alm[1], ALARM_ON); end
      one_minute = 1'b0;
      repeat (3) clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (alm[i] !== al_m[i] || obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL alarm_hold dut%0d got %b want %b", i, alm[i], al_m[i]); end
      end
      alarm_stop = 1'b1; clk_step(0, 0); alarm_stop = 1'b0; clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (alm[i] !== 1'b0) begin bad++; $display("FAIL alarm_stop dut%0d got %b want 0", i, alm[i]); end
      end
      load_start(8'h06, 8'h59, 0); load_end();
      one_minute = 1'b1; alarm_stop = 1'b1; clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (alm[i] !== 1'b0 || al_m[i] !== 1'b0) begin bad++; $display("FAIL alarm_stop_wins dut%0d got %b want 0", i, alm[i]); end
      end
      one_minute = 1'b0; alarm_stop = 1'b0; clk_step(0, 0);
      load_start(8'h07, 8'h00, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (alm[i] !== al_m[i] || alm[i] !== ALARM_ON) begin bad++; $display("FAIL alarm_on_load dut%0d got %b want %b", i, alm[i], ALARM_ON); end
      end
      load_end();
      alarm_arm = 1'b0; clk_step(0, 0);
      for (int i = 0; i < 2; i++) begin
         total++; if (alm[i] !== 1'b0) begin bad++; $display("FAIL alarm_disarm dut%0d got %b want 0", i, alm[i]); end
      end
   endtask

   task automatic test_random();
      load_start(to_bcd(int'($urandom_range(1, 12))), to_bcd(int'($urandom_range(0, 59))), 0);
      load_end();
      for (int n = 0; n < 400; n++) begin
         one_second = 1'($urandom % 2);
         one_minute = ($urandom % 3 == 0);
         clk_step(0, 0);
         for (int i = 0; i < 2; i++) begin
            total++; if (obs_vec(i) !== exp_vec(i)) begin bad++; $display("FAIL random_cyc%0d dut%0d got %h want %h", n, i, obs_vec(i), exp_vec(i)); end
         end
      end
      one_second = 1'b0; one_minute = 1'b0;
   endtask

   initial begin
      reset = 1'b1; one_second = 1'b0; one_minute = 1'b0; load_valid = 1'b0;
      load_hh = '0; load_mm = '0; alarm_hh = '0; alarm_mm = '0;
      alarm_arm = 1'b0; alarm_stop = 1'b0;
      model_reset();
      test_reset();
      test_minute_rollover();
      test_wrap();
      test_second_ticks();
      test_load_error();
      test_load_vs_tick();
      test_alarm();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "bench timed out");
   end

endmodule
